// File: rtl/iob_fp_mul_issue.sv
// Credit-gated issue/collect around the fixed-latency iob_fp_mul; results reach res_valid_o one cycle after mul_done_i,
// downstream back-pressure is absorbed by a DEPTH-entry FIFO. Optional flush port: `define IOB_FP_MUL_ISSUE_FLUSH_EN.
module iob_fp_mul_issue #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
`ifdef IOB_FP_MUL_ISSUE_FLUSH_EN
    input  logic              flush_i,
`endif
    input  logic              op_valid_i,
    output logic              op_ready_o,
    input  logic [DATA_W-1:0] op_a_i,
    input  logic [DATA_W-1:0] op_b_i,
    output logic              mul_start_o,
    output logic [DATA_W-1:0] mul_op_a_o,
    output logic [DATA_W-1:0] mul_op_b_o,
    input  logic              mul_done_i,
    input  logic [DATA_W-1:0] mul_res_i,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [DATA_W-1:0] res_o,
    output logic [CNT_W-1:0]  level_o,
    output logic              err_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [CNT_W-1:0]  inflight_q, inflight_d;
    logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [CNT_W-1:0]  level;
    logic              issue, pop, wr_en, stray, flush, done_discard;
    logic [CNT_W-1:0]  discard_q;

`ifdef IOB_FP_MUL_ISSUE_FLUSH_EN
    logic [CNT_W-1:0]  discard_d;
    assign flush = flush_i;
`else
    assign flush     = 1'b0;
    assign discard_q = '0;
`endif

    // Credits count every result slot already promised: buffered, in the pipe, or awaiting discard.
    assign level        = fifo_cnt_q + inflight_q + discard_q;
    assign op_ready_o   = (level < CNT_W'(DEPTH)) && !flush;
    assign issue        = op_valid_i && op_ready_o;
    assign res_valid_o  = (fifo_cnt_q != '0);
    assign pop          = res_valid_o && res_ready_i;
    assign done_discard = mul_done_i && (discard_q != '0);
    assign wr_en        = mul_done_i && (discard_q == '0) && (inflight_q != '0);
    assign stray        = mul_done_i && (discard_q == '0) && (inflight_q == '0);

    assign mul_start_o  = issue;
    assign mul_op_a_o   = op_a_i;
    assign mul_op_b_o   = op_b_i;
    assign res_o        = res_valid_o ? mem_q[rd_ptr_q] : '0;
    assign level_o      = level;
    assign err_o        = err_q;

    always_comb begin
        inflight_d = inflight_q + CNT_W'(issue) - CNT_W'(wr_en);
        fifo_cnt_d = fifo_cnt_q + CNT_W'(wr_en) - CNT_W'(pop);
        wr_ptr_d   = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        err_d      = err_q | stray;
        if (flush) begin
            inflight_d = '0;
            fifo_cnt_d = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            inflight_q <= '0;
            fifo_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            fifo_cnt_q <= fifo_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            err_q      <= err_d;
        end
    end

`ifdef IOB_FP_MUL_ISSUE_FLUSH_EN
    // A done arriving in the flush cycle retires one outstanding op, so it is not carried into discard.
    always_comb begin
        discard_d = discard_q - CNT_W'(done_discard);
        if (flush) begin
            discard_d = discard_q + inflight_q - CNT_W'(done_discard | wr_en);
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            discard_q <= '0;
        end else begin
            discard_q <= discard_d;
        end
    end
`endif

    // Result storage carries no reset; res_o masks it while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (wr_en && !flush) begin
            mem_q[wr_ptr_q] <= mul_res_i;
        end
    end

endmodule

// File: tb/tb_iob_fp_mul_issue.sv
// Bench for iob_fp_mul_issue: behavioural 4-cycle multiplier plus an in-order queue reference model.
module tb_iob_fp_mul_issue;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int CW    = 4;
    localparam logic [31:0] ONE  = 32'h3F80_0000;
    localparam logic [31:0] TWO  = 32'h4000_0000;
    localparam logic [31:0] FOUR = 32'h4080_0000;

    logic          clk = 1'b0;
    logic          arst_n = 1'b0;
    logic          op_valid = 1'b0, op_ready, mul_start, mul_done, res_valid, err;
    logic          res_ready = 1'b0;
    logic [DW-1:0] op_a = '0, op_b = '0, mul_a, mul_b, mul_res, res;
    logic [CW-1:0] level;
`ifdef IOB_FP_MUL_ISSUE_FLUSH_EN
    logic          flush = 1'b0;
`endif

    always #5 clk = ~clk;

    iob_fp_mul_issue #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk_i       (clk),
        .arst_n_i    (arst_n),
`ifdef IOB_FP_MUL_ISSUE_FLUSH_EN
        .flush_i     (flush),
`endif
        .op_valid_i  (op_valid),
        .op_ready_o  (op_ready),
        .op_a_i      (op_a),
        .op_b_i      (op_b),
        .mul_start_o (mul_start),
        .mul_op_a_o  (mul_a),
        .mul_op_b_o  (mul_b),
        .mul_done_i  (mul_done),
        .mul_res_i   (mul_res),
        .res_valid_o (res_valid),
        .res_ready_i (res_ready),
        .res_o       (res),
        .level_o     (level),
        .err_o       (err)
    );

    // Truncating fp32 multiply for normal operands; exact 1.0 passes the other operand through.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        logic [9:0]  e;
        logic [22:0] m;
        if (b == ONE) return a;
        if (a == ONE) return b;
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {a[31] ^ b[31], 31'd0};
        p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
        if (p[47]) begin
            e = e + 10'd1;
            m = p[46:24];
        end else begin
            m = p[45:23];
        end
        return {a[31] ^ b[31], e[7:0], m};
    endfunction

    logic [3:0]    pv;
    logic [31:0]   pd [4];
    logic          stray_done = 1'b0;

    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            pv <= '0;
        end else begin
            pv    <= {pv[2:0], mul_start};
            pd[0] <= fmul(mul_a, mul_b);
            pd[1] <= pd[0];
            pd[2] <= pd[1];
            pd[3] <= pd[2];
        end
    end
    assign mul_done = pv[3] | stray_done;
    assign mul_res  = pd[3];

    typedef struct {
        logic [31:0] d;
        int          vis;
    } ent_t;

    ent_t exp_q[$];
    int   cyc = 0;
    logic err_exp = 1'b0;
    int   n_chk = 0, n_pass = 0;
    int   nstart, sent, guard, nout, next_k, k;
    logic acc, rr, v;
    logic [31:0] ra, rb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    endtask

    // Entered at posedge+1: check model vs outputs, drive inputs, advance one cycle.
    task automatic step(input logic vi, input logic [31:0] a, input logic [31:0] b,
                        input logic rri, output logic accepted);
        logic        ev;
        logic [31:0] ed;
        logic        iss;
        ev  = (exp_q.size() > 0) && (exp_q[0].vis <= cyc);
        ed  = ev ? exp_q[0].d : 32'd0;
        chk("res_valid", 32'(res_valid), 32'(ev));
        chk("res", res, ed);
        chk("level", 32'(level), 32'(exp_q.size()));
        chk("op_ready", 32'(op_ready), 32'(exp_q.size() < DEPTH));
        chk("err", 32'(err), 32'(err_exp));
        op_valid  = vi;
        op_a      = a;
        op_b      = b;
        res_ready = rri;
        iss = vi && (exp_q.size() < DEPTH);
        if (rri && ev) void'(exp_q.pop_front());
        if (iss) exp_q.push_back('{fmul(a, b), cyc + 5});
        #1;
        chk("mul_start", 32'(mul_start), 32'(iss));
        if (mul_start === 1'b1) nstart++;
        if (iss) begin
            chk("mul_op_a", mul_a, a);
            chk("mul_op_b", mul_b, b);
        end
        accepted = iss;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [31:0] rnd_op();
        return {1'b0, 8'($urandom_range(110, 140)), 23'($urandom)};
    endfunction

    initial begin
        @(posedge clk);
        #1;
        chk("rst_op_ready", 32'(op_ready), 32'd1);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res", res, 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_mul_start", 32'(mul_start), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        arst_n = 1'b1;

        // single op: 1.0 * 2.0
        step(1'b1, ONE, TWO, 1'b1, acc);
        for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 32'd0, 1'b1, acc);
        chk("single_valid", 32'(res_valid), 32'd1);
        chk("single_res", res, TWO);
        for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 32'd0, 1'b1, acc);
        chk("single_level", 32'(level), 32'd0);

        // back-pressure: 12 ops of 2.0*2.0 against a stalled consumer
        nstart = 0;
        sent   = 0;
        for (int i = 0; i < 14; i++) begin
            step(1'b1, TWO, TWO, 1'b0, acc);
            if (acc) sent++;
        end
        chk("bp_starts", 32'(nstart), 32'd8);
        chk("bp_level", 32'(level), 32'd8);
        chk("bp_ready", 32'(op_ready), 32'd0);
        chk("bp_head", res, FOUR);
        guard = 0;
        while ((sent < 12 || exp_q.size() > 0) && guard < 60) begin
            step(sent < 12, TWO, TWO, 1'b1, acc);
            if (acc) sent++;
            guard++;
        end
        chk("bp_drain_bound", 32'(guard < 60), 32'd1);
        chk("bp_total_starts", 32'(nstart), 32'd12);

        // pointer wrap: values k, random consumer
        k = 1;
        next_k = 1;
        nout = 0;
        guard = 0;
        while ((k <= 20 || exp_q.size() > 0) && guard < 400) begin
            rr = 1'($urandom_range(0, 1));
            v  = (k <= 20) && ($urandom_range(0, 3) != 0);
            if (res_valid && rr) begin
                chk("wrap_val", res, 32'(next_k));
                next_k++;
                nout++;
            end
            step(v, 32'(k), ONE, rr, acc);
            if (acc) k++;
            guard++;
        end
        chk("wrap_bound", 32'(guard < 400), 32'd1);
        chk("wrap_count", 32'(nout), 32'd20);

        // steady stream with an always-ready consumer
        for (int i = 0; i < 36; i++) begin
            ra = rnd_op();
            rb = rnd_op();
            step(i < 30, ra, rb, 1'b1, acc);
            if (i >= 4 && i < 30) begin
                chk("steady_level_range", 32'(level >= 4 && level <= 5), 32'd1);
                chk("steady_ready", 32'(op_ready), 32'd1);
            end
        end

        // async reset mid-stream
        for (int i = 0; i < 6; i++) step(1'b1, rnd_op(), rnd_op(), 1'b0, acc);
        op_valid = 1'b0;
        #1;
        arst_n = 1'b0;
        #1;
        chk("mid_rst_op_ready", 32'(op_ready), 32'd1);
        chk("mid_rst_res_valid", 32'(res_valid), 32'd0);
        chk("mid_rst_res", res, 32'd0);
        chk("mid_rst_level", 32'(level), 32'd0);
        chk("mid_rst_mul_start", 32'(mul_start), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        @(posedge clk);
        #1;
        arst_n = 1'b1;
        exp_q.delete();
        err_exp = 1'b0;
        cyc++;
        for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 32'd0, 1'b1, acc);

        // stray done with nothing in flight
        stray_done = 1'b1;
        step(1'b0, 32'd0, 32'd0, 1'b1, acc);
        stray_done = 1'b0;
        err_exp = 1'b1;
        chk("stray_err", 32'(err), 32'd1);
        chk("stray_res_valid", 32'(res_valid), 32'd0);
        for (int i = 0; i < 2; i++) step(1'b0, 32'd0, 32'd0, 1'b1, acc);

`ifdef IOB_FP_MUL_ISSUE_FLUSH_EN
        // flush with 2 buffered and 3 in flight
        arst_n = 1'b0;
        #1;
        arst_n = 1'b1;
        exp_q.delete();
        err_exp = 1'b0;
        for (int i = 0; i < 2; i++) step(1'b1, ONE, TWO, 1'b0, acc);
        for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 32'd0, 1'b0, acc);
        for (int i = 0; i < 3; i++) step(1'b1, TWO, TWO, 1'b0, acc);
        chk("pre_flush_level", 32'(level), 32'd5);
        op_valid = 1'b0;
        flush = 1'b1;
        #1;
        chk("flush_ready", 32'(op_ready), 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_res_valid", 32'(res_valid), 32'd0);
        chk("flush_level", 32'(level), 32'd3);
        chk("flush_err", 32'(err), 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            chk("post_flush_res_valid", 32'(res_valid), 32'd0);
            chk("post_flush_err", 32'(err), 32'd0);
        end
        chk("post_flush_level", 32'(level), 32'd0);
        exp_q.delete();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
